// File: rtl/rect_drop_ctl.sv
// Frame-synchronous sprite position controller: follows the mouse, or drops and bounces on click.
// Optional build macro RECT_DROP_RESTART_EN lets a click abort a drop in flight.
module rect_drop_ctl #(
   parameter int SCREEN_W   = 800,
   parameter int SCREEN_H   = 600,
   parameter int RECT_W     = 64,
   parameter int RECT_H     = 64,
   parameter int GRAVITY    = 1,
   parameter int V_MAX      = 31,
   parameter int DAMP_SHIFT = 1
) (
   input  logic        pclk,
   input  logic        rst,
   input  logic        vblnk_in,
   input  logic [11:0] mouse_xpos,
   input  logic [11:0] mouse_ypos,
   input  logic        mouse_left,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FALL = 2'd1,
      RISE = 2'd2,
      REST = 2'd3
   } state_t;

   localparam logic [11:0] XMAX_C  = 12'(SCREEN_W - RECT_W);
   localparam logic [11:0] FLOOR_C = 12'(SCREEN_H - RECT_H);
   localparam logic [12:0] VMAX_C  = 13'(V_MAX);
   localparam logic [12:0] GRAV_C  = 13'(GRAVITY);
   localparam logic [5:0]  GRAV6_C = 6'(GRAVITY);

   state_t      state_q, state_d;
   logic [11:0] xpos_q, xpos_d;
   logic [11:0] ypos_q, ypos_d;
   logic [5:0]  vel_q, vel_d;
   logic        busy_q, busy_d;
   logic        click_pend_q, click_pend_d;
   logic        vblnk_d_q;
   logic        left_d_q;

   logic        tick_s;
   logic        click_s;
   logic        pend_s;
   logic        restart_s;
   logic [12:0] vel_inc_s;
   logic [5:0]  fall_vel_s;
   logic [12:0] fall_sum_s;
   logic [5:0]  damp_vel_s;
   logic [5:0]  rise_vel_s;

   function automatic logic [11:0] clamp(input logic [11:0] v, input logic [11:0] lim);
      if (v > lim) begin
         return lim;
      end else begin
         return v;
      end
   endfunction

   assign tick_s  = vblnk_in & ~vblnk_d_q;
   assign click_s = mouse_left & ~left_d_q;
   assign pend_s  = click_pend_q | click_s;

`ifdef RECT_DROP_RESTART_EN
   assign restart_s = pend_s;
`else
   assign restart_s = 1'b0;
`endif

   assign vel_inc_s  = {7'b0, vel_q} + GRAV_C;
   assign fall_vel_s = (vel_inc_s > VMAX_C) ? VMAX_C[5:0] : vel_inc_s[5:0];
   assign fall_sum_s = {1'b0, ypos_q} + {7'b0, fall_vel_s};
   assign damp_vel_s = fall_vel_s >> DAMP_SHIFT;
   assign rise_vel_s = (vel_q > GRAV6_C) ? (vel_q - GRAV6_C) : 6'd0;

   // Next-state logic: everything except the click latch moves only on a vblank tick.
   always_comb begin
      state_d      = state_q;
      xpos_d       = xpos_q;
      ypos_d       = ypos_q;
      vel_d        = vel_q;
      click_pend_d = pend_s;
      if (tick_s) begin
         click_pend_d = 1'b0;
         case (state_q)
            IDLE: begin
               if (pend_s) begin
                  state_d = FALL;
                  vel_d   = 6'd0;
               end else begin
                  xpos_d = clamp(mouse_xpos, XMAX_C);
                  ypos_d = clamp(mouse_ypos, FLOOR_C);
               end
            end
            FALL: begin
               if (restart_s) begin
                  state_d = IDLE;
                  vel_d   = 6'd0;
                  xpos_d  = clamp(mouse_xpos, XMAX_C);
                  ypos_d  = clamp(mouse_ypos, FLOOR_C);
               end else if (fall_sum_s >= {1'b0, FLOOR_C}) begin
                  ypos_d  = FLOOR_C;
                  vel_d   = damp_vel_s;
                  state_d = (damp_vel_s != 6'd0) ? RISE : REST;
               end else begin
                  ypos_d = fall_sum_s[11:0];
                  vel_d  = fall_vel_s;
               end
            end
            RISE: begin
               if (restart_s) begin
                  state_d = IDLE;
                  vel_d   = 6'd0;
                  xpos_d  = clamp(mouse_xpos, XMAX_C);
                  ypos_d  = clamp(mouse_ypos, FLOOR_C);
               end else if (ypos_q < {6'b0, vel_q}) begin
                  ypos_d  = 12'd0;
                  vel_d   = 6'd0;
                  state_d = FALL;
               end else begin
                  ypos_d  = ypos_q - {6'b0, vel_q};
                  vel_d   = rise_vel_s;
                  state_d = (rise_vel_s == 6'd0) ? FALL : RISE;
               end
            end
            REST: begin
               if (pend_s) begin
                  state_d = IDLE;
                  xpos_d  = clamp(mouse_xpos, XMAX_C);
                  ypos_d  = clamp(mouse_ypos, FLOOR_C);
               end else begin
                  state_d = REST;
               end
            end
            default: begin
               state_d = IDLE;
               vel_d   = 6'd0;
            end
         endcase
      end else begin
         state_d = state_q;
      end
      busy_d = (state_d == FALL) || (state_d == RISE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state_q      <= IDLE;
         xpos_q       <= 12'd0;
         ypos_q       <= 12'd0;
         vel_q        <= 6'd0;
         busy_q       <= 1'b0;
         click_pend_q <= 1'b0;
         left_d_q     <= 1'b0;
         // Track vblank through reset so a level already high at release is not a new edge.
         vblnk_d_q    <= vblnk_in;
      end else begin
         state_q      <= state_d;
         xpos_q       <= xpos_d;
         ypos_q       <= ypos_d;
         vel_q        <= vel_d;
         busy_q       <= busy_d;
         click_pend_q <= click_pend_d;
         left_d_q     <= mouse_left;
         vblnk_d_q    <= vblnk_in;
      end
   end

   assign xpos = xpos_q;
   assign ypos = ypos_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_rect_drop_ctl.sv
// Directed bench for rect_drop_ctl: mouse-follow vector table plus hand-traced drop/bounce sequences.
module tb_rect_drop_ctl;

   logic        pclk;
   logic        rst;
   logic        vblnk_in;
   logic [11:0] mouse_xpos;
   logic [11:0] mouse_ypos;
   logic        mouse_left;
   logic [11:0] xpos;
   logic [11:0] ypos;
   logic        busy;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [11:0] mx;
      logic [11:0] my;
      logic [11:0] ex;
      logic [11:0] ey;
   } vec_t;

   vec_t vecs[7];

   rect_drop_ctl dut (
      .pclk       (pclk),
      .rst        (rst),
      .vblnk_in   (vblnk_in),
      .mouse_xpos (mouse_xpos),
      .mouse_ypos (mouse_ypos),
      .mouse_left (mouse_left),
      .xpos       (xpos),
      .ypos       (ypos),
      .busy       (busy)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic check3(input string name, input logic [11:0] ex, input logic [11:0] ey,
                         input logic eb);
      check({name, ".x"}, xpos, ex);
      check({name, ".y"}, ypos, ey);
      check({name, ".busy"}, {11'd0, busy}, {11'd0, eb});
   endtask

   task automatic tick();
      @(negedge pclk);
      vblnk_in = 1'b1;
      @(negedge pclk);
      vblnk_in = 1'b0;
   endtask

   task automatic click();
      @(negedge pclk);
      mouse_left = 1'b1;
      @(negedge pclk);
      mouse_left = 1'b0;
   endtask

   task automatic click_tick();
      @(negedge pclk);
      mouse_left = 1'b1;
      vblnk_in   = 1'b1;
      @(negedge pclk);
      mouse_left = 1'b0;
      vblnk_in   = 1'b0;
   endtask

   task automatic set_mouse(input logic [11:0] mx, input logic [11:0] my);
      mouse_xpos = mx;
      mouse_ypos = my;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int done_n;
      rst        = 1'b1;
      vblnk_in   = 1'b0;
      mouse_left = 1'b0;
      set_mouse(12'd0, 12'd0);

      vecs[0] = '{mx: 12'd100,  my: 12'd200,  ex: 12'd100, ey: 12'd200};
      vecs[1] = '{mx: 12'd900,  my: 12'd700,  ex: 12'd736, ey: 12'd536};
      vecs[2] = '{mx: 12'd736,  my: 12'd536,  ex: 12'd736, ey: 12'd536};
      vecs[3] = '{mx: 12'd737,  my: 12'd537,  ex: 12'd736, ey: 12'd536};
      vecs[4] = '{mx: 12'd0,    my: 12'd0,    ex: 12'd0,   ey: 12'd0};
      vecs[5] = '{mx: 12'd4095, my: 12'd4095, ex: 12'd736, ey: 12'd536};
      vecs[6] = '{mx: 12'd12,   my: 12'd599,  ex: 12'd12,  ey: 12'd536};

      // Reset held while vblank toggles; leave vblank high going out of reset.
      set_mouse(12'd100, 12'd100);
      for (int i = 0; i < 4; i++) begin
         @(negedge pclk);
         check3("reset", 12'd0, 12'd0, 1'b0);
         vblnk_in = (i % 2 == 1);
      end
      @(negedge pclk);
      rst = 1'b0;
      repeat (3) @(negedge pclk);
      check3("no_tick_after_reset", 12'd0, 12'd0, 1'b0);
      vblnk_in = 1'b0;

      for (int i = 0; i < 7; i++) begin
         set_mouse(vecs[i].mx, vecs[i].my);
         tick();
         check3($sformatf("follow[%0d]", i), vecs[i].ex, vecs[i].ey, 1'b0);
      end

      // No tick: mouse motion must not reach the outputs.
      set_mouse(12'd300, 12'd300);
      repeat (4) @(negedge pclk);
      check3("hold_between_ticks", 12'd12, 12'd536, 1'b0);

      // Vblank held high produces a single tick.
      @(negedge pclk);
      set_mouse(12'd10, 12'd10);
      vblnk_in = 1'b1;
      @(negedge pclk);
      check3("held_vblnk_first", 12'd10, 12'd10, 1'b0);
      set_mouse(12'd20, 12'd20);
      repeat (3) @(negedge pclk);
      check3("held_vblnk_rest", 12'd10, 12'd10, 1'b0);
      vblnk_in = 1'b0;

      // Full drop from the top; click arrives in the same cycle as the tick.
      set_mouse(12'd40, 12'd0);
      tick();
      check3("drop_start_pos", 12'd40, 12'd0, 1'b0);
      set_mouse(12'd50, 12'd300);
      click_tick();
      check3("click_with_tick", 12'd40, 12'd0, 1'b1);
      done_n = 0;
      for (int n = 1; n <= 150; n++) begin
         tick();
         case (n)
            1:  check("fall_t1", ypos, 12'd1);
            2:  check("fall_t2", ypos, 12'd3);
            3:  check("fall_t3", ypos, 12'd6);
            4:  check("fall_t4", ypos, 12'd10);
            31: check("fall_t31", ypos, 12'd496);
            32: check("fall_t32_vmax", ypos, 12'd527);
            33: check3("first_floor_hit", 12'd40, 12'd536, 1'b1);
            48: check3("rise_apex", 12'd40, 12'd416, 1'b1);
            63: check3("second_floor_hit", 12'd40, 12'd536, 1'b1);
            default: ;
         endcase
         if (!busy) begin
            done_n = n;
            break;
         end
      end
      check("ticks_to_rest", 12'(done_n), 12'd85);
      check3("rest", 12'd40, 12'd536, 1'b0);

      // Click in REST returns to IDLE and loads the mouse on the same tick.
      click();
      tick();
      check3("rest_click", 12'd50, 12'd300, 1'b0);

      // Click during FALL.
      set_mouse(12'd40, 12'd0);
      tick();
      click_tick();
      repeat (3) tick();
      check3("fall2_t3", 12'd40, 12'd6, 1'b1);
      set_mouse(12'd60, 12'd70);
      click();
      tick();
`ifdef RECT_DROP_RESTART_EN
      check3("fall_click_restart", 12'd60, 12'd70, 1'b0);
      tick();
      check3("after_restart_idle", 12'd60, 12'd70, 1'b0);
`else
      check3("fall_click_ignored", 12'd40, 12'd10, 1'b1);
      tick();
      check3("fall_after_ignored", 12'd40, 12'd15, 1'b1);
`endif

      // Reset while in RISE.
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      rst = 1'b0;
      set_mouse(12'd40, 12'd530);
      tick();
      click_tick();
      tick();
      check("near_floor_t1", ypos, 12'd531);
      tick();
      check("near_floor_t2", ypos, 12'd533);
      tick();
      check3("near_floor_rise", 12'd40, 12'd536, 1'b1);
      @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      check3("reset_in_rise", 12'd0, 12'd0, 1'b0);
      rst = 1'b0;
      set_mouse(12'd77, 12'd88);
      tick();
      check3("follow_after_reset", 12'd77, 12'd88, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
